// File: rtl/aes_axi_stream_slave_pkg.sv
// Shared constants and block-packing helper for the AES AXI4-Stream slave.
// Provides word size, words per block and the word placement function.
package aes_axi_stream_slave_pkg;

   localparam int WORD_S = 32;
   localparam int NB     = 4;
   localparam int BLK_W  = WORD_S * NB;

   // Writes word w at index idx (index 0 is the MSW).
   // With zero_tail set, every word after idx is cleared.
   function automatic logic [BLK_W-1:0] place_word(
      input logic [BLK_W-1:0]  blk,
      input logic [1:0]        idx,
      input logic [WORD_S-1:0] w,
      input logic              zero_tail
   );
      logic [BLK_W-1:0] r;
      r = blk;
      for (int i = 0; i < NB; i++) begin
         if (i == int'(idx))
            r[BLK_W-1-WORD_S*i -: WORD_S] = w;
         else if (zero_tail && i > int'(idx))
            r[BLK_W-1-WORD_S*i -: WORD_S] = '0;
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_axi_stream_slave_fifo.sv
// Block FIFO with show-ahead head data and synchronous flush.
// Ports: clk, reset, wr_en/wr_data, rd_en/rd_data, empty, full, almost_full.
module aes_axi_stream_slave_fifo #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 128,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full
);

   localparam logic [ADDR_WIDTH:0] CNT_FULL =
      (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] CNT_AF =
      (ADDR_WIDTH+1)'(DEPTH-1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count;
   logic                  do_wr;
   logic                  do_rd;

   assign full        = (count == CNT_FULL);
   assign empty       = (count == '0);
   assign almost_full = (count >= CNT_AF);
   assign do_wr       = wr_en && !full;
   assign do_rd       = rd_en && !empty;
   assign rd_data     = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_rd)
            rd_ptr <= rd_ptr + 1'b1;
         if (do_wr && !do_rd)
            count <= count + 1'b1;
         else if (!do_wr && do_rd)
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/aes_axi_stream_slave.sv
// AXI4-Stream slave: first beat is the command, then 4 beats per block.
// Ports: s00_axis_* stream in, aes_cmd out, in_fifo_* block FIFO, status pulses.
module aes_axi_stream_slave
   import aes_axi_stream_slave_pkg::*;
#(
   parameter int C_S_AXIS_TDATA_WIDTH = 32,
   parameter int FIFO_SIZE            = 16,
   parameter int FIFO_ADDR_WIDTH      = 4,
   parameter int FIFO_DATA_WIDTH      = 128
) (
   input  logic                            s00_axis_aclk,
   input  logic                            s00_axis_areset,
   input  logic                            s00_axis_tvalid,
   output logic                            s00_axis_tready,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
   input  logic [3:0]                      s00_axis_tstrb,
   input  logic                            s00_axis_tlast,
   output logic [WORD_S-1:0]               aes_cmd,
   output logic                            aes_cmd_valid,
   output logic [FIFO_DATA_WIDTH-1:0]      in_fifo_data,
   output logic                            in_fifo_read_tvalid,
   input  logic                            in_fifo_read_tready,
   output logic                            in_fifo_empty,
   output logic                            in_fifo_full,
   output logic                            in_fifo_almost_full,
   output logic                            protocol_err,
   output logic                            axis_slave_done
);

   typedef enum logic {ST_CMD, ST_DATA} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [1:0]           word_cnt;
   logic [BLK_W-1:0]     asm_blk;
   logic                 blk_pending;
   logic                 beat;
   logic                 fifo_wr;
   logic                 unused_tstrb;

   assign unused_tstrb = ^s00_axis_tstrb;
   assign beat    = s00_axis_tvalid && s00_axis_tready;
   assign fifo_wr = blk_pending && !in_fifo_full;
   assign in_fifo_read_tvalid = !in_fifo_empty;

   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset)
         state <= ST_CMD;
      else
         state <= state_nxt;
   end

   // A full FIFO only stalls data beats once a finished
   // block is waiting, since that block owns asm_blk.
   always_comb begin
      s00_axis_tready = 1'b0;
      state_nxt       = state;
      if (!s00_axis_areset) begin
         unique case (state)
            ST_CMD: begin
               s00_axis_tready = 1'b1;
               if (s00_axis_tvalid && !s00_axis_tlast)
                  state_nxt = ST_DATA;
            end
            ST_DATA: begin
               s00_axis_tready = !blk_pending || !in_fifo_full;
               if (s00_axis_tvalid && s00_axis_tready
                   && s00_axis_tlast)
                  state_nxt = ST_CMD;
            end
         endcase
      end
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) begin
         word_cnt        <= '0;
         asm_blk         <= '0;
         blk_pending     <= 1'b0;
         aes_cmd         <= '0;
         aes_cmd_valid   <= 1'b0;
         protocol_err    <= 1'b0;
         axis_slave_done <= 1'b0;
      end else begin
         aes_cmd_valid   <= 1'b0;
         protocol_err    <= 1'b0;
         axis_slave_done <= 1'b0;
         if (fifo_wr)
            blk_pending <= 1'b0;
         if (beat) begin
            if (state == ST_CMD) begin
               aes_cmd         <= s00_axis_tdata;
               aes_cmd_valid   <= 1'b1;
               word_cnt        <= '0;
               axis_slave_done <= s00_axis_tlast;
            end else begin
               asm_blk  <= place_word(asm_blk, word_cnt,
                                      s00_axis_tdata,
                                      s00_axis_tlast);
               word_cnt <= word_cnt + 2'd1;
               // Set wins over the clear above when a new
               // block completes during a FIFO write.
               if (word_cnt == 2'd3 || s00_axis_tlast)
                  blk_pending <= 1'b1;
               if (s00_axis_tlast) begin
                  word_cnt        <= '0;
                  axis_slave_done <= 1'b1;
                  protocol_err    <= (word_cnt != 2'd3);
               end
            end
         end
      end
   end

   aes_axi_stream_slave_fifo #(
      .ADDR_WIDTH (FIFO_ADDR_WIDTH),
      .DATA_WIDTH (FIFO_DATA_WIDTH),
      .DEPTH      (FIFO_SIZE)
   ) slave_fifo (
      .clk         (s00_axis_aclk),
      .reset       (s00_axis_areset),
      .wr_en       (fifo_wr),
      .wr_data     (asm_blk),
      .rd_en       (in_fifo_read_tready),
      .rd_data     (in_fifo_data),
      .empty       (in_fifo_empty),
      .full        (in_fifo_full),
      .almost_full (in_fifo_almost_full)
   );

endmodule

// File: tb/tb_aes_axi_stream_slave.sv
// Directed bench for aes_axi_stream_slave with a block scoreboard.
// Drives stream beats, pops the block FIFO and compares in order.
module tb_aes_axi_stream_slave;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         tvalid = 1'b0;
   logic         tready;
   logic [31:0]  tdata = '0;
   logic [3:0]   tstrb = 4'hF;
   logic         tlast = 1'b0;
   logic [31:0]  aes_cmd;
   logic         aes_cmd_valid;
   logic [127:0] in_fifo_data;
   logic         in_fifo_read_tvalid;
   logic         rd_tready = 1'b0;
   logic         in_fifo_empty;
   logic         in_fifo_full;
   logic         in_fifo_almost_full;
   logic         protocol_err;
   logic         axis_slave_done;

   int n_tests = 0;
   int n_fail  = 0;
   int n_cmdv  = 0;
   int n_done  = 0;
   int n_perr  = 0;
   int cmode   = 0;
   int pop_req = 0;
   logic [127:0] exp_q [$];

   always #5 clk = ~clk;

   aes_axi_stream_slave dut (
      .s00_axis_aclk       (clk),
      .s00_axis_areset     (rst),
      .s00_axis_tvalid     (tvalid),
      .s00_axis_tready     (tready),
      .s00_axis_tdata      (tdata),
      .s00_axis_tstrb      (tstrb),
      .s00_axis_tlast      (tlast),
      .aes_cmd             (aes_cmd),
      .aes_cmd_valid       (aes_cmd_valid),
      .in_fifo_data        (in_fifo_data),
      .in_fifo_read_tvalid (in_fifo_read_tvalid),
      .in_fifo_read_tready (rd_tready),
      .in_fifo_empty       (in_fifo_empty),
      .in_fifo_full        (in_fifo_full),
      .in_fifo_almost_full (in_fifo_almost_full),
      .protocol_err        (protocol_err),
      .axis_slave_done     (axis_slave_done)
   );

   task automatic check(input string tag,
                        input logic [127:0] got,
                        input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (aes_cmd_valid === 1'b1) n_cmdv++;
         if (axis_slave_done === 1'b1) n_done++;
         if (protocol_err === 1'b1) n_perr++;
      end
   end

   // Consumer: mode 0 hold, 1 always ready, 2 random.
   always @(negedge clk) begin
      if (pop_req > 0)
         rd_tready = 1'b1;
      else if (cmode == 2)
         rd_tready = 1'($urandom_range(0, 1));
      else
         rd_tready = (cmode == 1);
      #1;
      if (rd_tready && in_fifo_read_tvalid) begin
         if (exp_q.size() == 0)
            check("blk_extra", 1, 0);
         else begin
            check("blk_data", in_fifo_data, exp_q[0]);
            void'(exp_q.pop_front());
         end
         if (pop_req > 0) pop_req--;
      end
   end

   task automatic beat(input logic [31:0] d,
                       input logic l,
                       input int gap);
      int n;
      if (gap > 0) begin
         @(negedge clk);
         tvalid = 1'b0;
         repeat (gap - 1) @(negedge clk);
      end
      @(negedge clk);
      tvalid = 1'b1;
      tdata  = d;
      tlast  = l;
      n = 0;
      #1;
      while (!tready) begin
         if (n == 2000) begin
            check("beat_timeout", 0, 1);
            break;
         end
         @(negedge clk);
         #1;
         n++;
      end
      @(posedge clk);
   endtask

   task automatic end_pkt();
      @(negedge clk);
      tvalid = 1'b0;
      tlast  = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || !in_fifo_empty)
             && n < 4000) begin
         @(negedge clk);
         #3;
         n++;
      end
      check(tag, exp_q.size(), 0);
   endtask

   initial begin
      logic [31:0]  w [4];
      logic [127:0] blk;
      int c0, d0, p0, blocks, nb;

      // Reset state
      repeat (3) @(negedge clk);
      #2;
      check("rst_tready", tready, 0);
      check("rst_cmd", aes_cmd, 0);
      check("rst_cmdv", aes_cmd_valid, 0);
      check("rst_perr", protocol_err, 0);
      check("rst_done", axis_slave_done, 0);
      check("rst_empty", in_fifo_empty, 1);
      check("rst_rdvalid", in_fifo_read_tvalid, 0);
      @(negedge clk);
      rst = 1'b0;
      #2;
      check("rst_tready_after", tready, 1);

      // Basic packet and latency
      c0 = n_cmdv; d0 = n_done; p0 = n_perr;
      exp_q.push_back(128'h00112233_44556677_8899AABB_CCDDEEFF);
      beat(32'hA5A5_0001, 0, 0);
      beat(32'h0011_2233, 0, 0);
      beat(32'h4455_6677, 0, 0);
      beat(32'h8899_AABB, 0, 0);
      beat(32'hCCDD_EEFF, 1, 0);
      end_pkt();
      #2;
      check("t1_done_pulse", axis_slave_done, 1);
      check("t1_lat_n1", in_fifo_read_tvalid, 0);
      @(negedge clk);
      #2;
      check("t1_lat_n2", in_fifo_read_tvalid, 1);
      check("t1_head", in_fifo_data,
            128'h00112233_44556677_8899AABB_CCDDEEFF);
      check("t1_cmd", aes_cmd, 32'hA5A5_0001);
      cmode = 1;
      wait_drain("t1_drain");
      cmode = 0;
      check("t1_cmdv_cnt", n_cmdv - c0, 1);
      check("t1_done_cnt", n_done - d0, 1);
      check("t1_perr_cnt", n_perr - p0, 0);

      // Fill to full, stall, pop, refill
      c0 = n_cmdv; d0 = n_done; p0 = n_perr;
      beat(32'h0000_0017, 0, 0);
      for (int b = 0; b < 17; b++) begin
         for (int k = 0; k < 4; k++)
            w[k] = {16'hB000, 8'(b), 8'(k)};
         exp_q.push_back({w[0], w[1], w[2], w[3]});
         for (int k = 0; k < 4; k++)
            beat(w[k], 0, 0);
      end
      end_pkt();
      #2;
      check("t2_full", in_fifo_full, 1);
      check("t2_afull", in_fifo_almost_full, 1);
      check("t2_stall", tready, 0);
      @(posedge clk);
      #1;
      pop_req = 1;
      @(posedge clk);
      @(negedge clk);
      #2;
      check("t2_wr_refused", in_fifo_full, 0);
      @(negedge clk);
      #2;
      check("t2_refill", in_fifo_full, 1);
      cmode = 1;
      for (int k = 0; k < 4; k++)
         w[k] = {16'hB000, 8'd17, 8'(k)};
      exp_q.push_back({w[0], w[1], w[2], w[3]});
      for (int k = 0; k < 4; k++)
         beat(w[k], k == 3, 0);
      end_pkt();
      wait_drain("t2_drain");
      check("t2_cmdv_cnt", n_cmdv - c0, 1);
      check("t2_done_cnt", n_done - d0, 1);
      check("t2_perr_cnt", n_perr - p0, 0);

      // Short final block
      c0 = n_cmdv; d0 = n_done; p0 = n_perr;
      exp_q.push_back(128'h30000001_30000002_30000003_30000004);
      exp_q.push_back(128'h30000005_30000006_00000000_00000000);
      beat(32'h0000_0033, 0, 0);
      for (int k = 1; k <= 6; k++)
         beat(32'h3000_0000 | 32'(k), k == 6, 0);
      end_pkt();
      wait_drain("t3_drain");
      check("t3_perr_cnt", n_perr - p0, 1);
      check("t3_done_cnt", n_done - d0, 1);

      // Command-only packet
      cmode = 0;
      c0 = n_cmdv; d0 = n_done; p0 = n_perr;
      beat(32'hC0DE_0004, 1, 0);
      end_pkt();
      repeat (4) @(negedge clk);
      #2;
      check("t4_cmd", aes_cmd, 32'hC0DE_0004);
      check("t4_cmdv_cnt", n_cmdv - c0, 1);
      check("t4_done_cnt", n_done - d0, 1);
      check("t4_no_write", in_fifo_empty, 1);
      check("t4_perr_cnt", n_perr - p0, 0);

      // Reset mid-packet
      beat(32'h0000_0044, 0, 0);
      for (int k = 0; k < 4; k++)
         beat(32'h4400_0000 | 32'(k), k == 3, 0);
      beat(32'h0000_0045, 0, 0);
      beat(32'h4500_0000, 0, 0);
      beat(32'h4500_0001, 0, 0);
      end_pkt();
      #2;
      check("t5_pre_fill", in_fifo_read_tvalid, 1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      check("t5_rst_tready", tready, 0);
      rst = 1'b0;
      #2;
      check("t5_flush", in_fifo_empty, 1);
      check("t5_rdvalid", in_fifo_read_tvalid, 0);
      check("t5_cmd_clr", aes_cmd, 0);
      check("t5_tready", tready, 1);
      exp_q.push_back(128'h55000000_55000001_55000002_55000003);
      beat(32'h0000_0055, 0, 0);
      for (int k = 0; k < 4; k++)
         beat(32'h5500_0000 | 32'(k), k == 3, 0);
      end_pkt();
      cmode = 1;
      wait_drain("t5_drain");

      // Random gaps and random consumer over 100 blocks
      cmode = 2;
      p0 = n_perr;
      blocks = 0;
      while (blocks < 100) begin
         nb = $urandom_range(1, 4);
         if (nb > 100 - blocks) nb = 100 - blocks;
         beat($urandom, 0, $urandom_range(0, 2));
         for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < 4; k++)
               w[k] = $urandom;
            blk = {w[0], w[1], w[2], w[3]};
            exp_q.push_back(blk);
            for (int k = 0; k < 4; k++)
               beat(w[k], (b == nb - 1) && (k == 3),
                    $urandom_range(0, 2));
         end
         end_pkt();
         blocks += nb;
      end
      cmode = 1;
      wait_drain("t6_drain");
      check("t6_perr_cnt", n_perr - p0, 0);
      check("t6_empty", in_fifo_empty, 1);

      $display("[TB] %0d tests run, %0d failed",
               n_tests, n_fail);
      $finish;
   end

endmodule
